// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN layer sequencer: state encodings,
// timer channel indices and default stage thresholds.
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_POOL = 3'd2,
        S_ACT  = 3'd3,
        S_FC   = 3'd4,
        S_RESP = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    localparam int NUM_CH  = 4;
    localparam int CH_CONV = 0;
    localparam int CH_POOL = 1;
    localparam int CH_ACT  = 2;
    localparam int CH_FC   = 3;

    localparam int THR_CONV_DEF = 70;
    localparam int THR_POOL_DEF = 31;
    localparam int THR_ACT_DEF  = 1;
    localparam int THR_FC_DEF   = 1085;

    function automatic logic is_run(input state_e s);
        return (s == S_CONV) || (s == S_POOL) || (s == S_ACT) || (s == S_FC);
    endfunction

    // One-hot timer enable for a state; zero outside the four run states.
    function automatic logic [NUM_CH-1:0] stage_en(input state_e s);
        logic [NUM_CH-1:0] en;
        en = '0;
        case (s)
            S_CONV:  en[CH_CONV] = 1'b1;
            S_POOL:  en[CH_POOL] = 1'b1;
            S_ACT:   en[CH_ACT]  = 1'b1;
            S_FC:    en[CH_FC]   = 1'b1;
            default: en = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage watchdog: counter clears on stage entry, counts while a stage runs,
// and flags timeout once it reaches TIMEOUT-1.
module seq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != LAST))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign timeout = inc && (cnt_q == LAST);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame controller stepping CONV/POOL x N_LAYERS, ACT, FC through the timer bank,
// reporting frame latency and trapping hung stages in ERR.
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int N_LAYERS = 2,
    parameter int TIMEOUT  = 4096,
    parameter int CYC_W    = 16
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              start_valid,
    output logic                              start_ready,
    input  logic                              abort,
    output logic [3:0]                        timer_en,
    input  logic [3:0]                        timer_done,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [CYC_W-1:0]                  res_cycles,
    output logic                              busy,
    output logic                              err,
    output logic [2:0]                        stage,
    output logic [$clog2(N_LAYERS+1)-1:0]     layer_idx
);

    localparam int LW = $clog2(N_LAYERS + 1);

    state_e            state_q, state_d;
    logic [3:0]        timer_en_q, timer_en_d;
    logic [CYC_W-1:0]  res_cycles_q, res_cycles_d;
    logic [LW-1:0]     layer_idx_q, layer_idx_d;
    logic              wd_timeout;
    logic              last_layer;

    assign last_layer = (layer_idx_q == LW'(N_LAYERS - 1));

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (S_AXIS_ACLK),
        .rst_n   (S_AXIS_ARESETN),
        .clr     (state_d != state_q),
        .inc     (is_run(state_q)),
        .timeout (wd_timeout)
    );

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q      <= S_IDLE;
            timer_en_q   <= '0;
            res_cycles_q <= '0;
            layer_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_en_q   <= timer_en_d;
            res_cycles_q <= res_cycles_d;
            layer_idx_q  <= layer_idx_d;
        end
    end

    // Only the running stage's done bit is looked at; done beats timeout.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_valid) state_d = S_CONV;
                S_CONV: begin
                    if (timer_done[CH_CONV])  state_d = S_POOL;
                    else if (wd_timeout)      state_d = S_ERR;
                end
                S_POOL: begin
                    if (timer_done[CH_POOL])  state_d = last_layer ? S_ACT : S_CONV;
                    else if (wd_timeout)      state_d = S_ERR;
                end
                S_ACT: begin
                    if (timer_done[CH_ACT])   state_d = S_FC;
                    else if (wd_timeout)      state_d = S_ERR;
                end
                S_FC: begin
                    if (timer_done[CH_FC])    state_d = S_RESP;
                    else if (wd_timeout)      state_d = S_ERR;
                end
                S_RESP: if (res_ready) state_d = S_IDLE;
                S_ERR:  state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        res_cycles_d = res_cycles_q;
        layer_idx_d  = layer_idx_q;
        if (abort) begin
            res_cycles_d = '0;
            layer_idx_d  = '0;
        end else begin
            if ((state_q == S_IDLE) && start_valid) begin
                res_cycles_d = '0;
                layer_idx_d  = '0;
            end else if (is_run(state_q) && (res_cycles_q != '1)) begin
                res_cycles_d = res_cycles_q + 1'b1;
            end
            if ((state_q == S_POOL) && timer_done[CH_POOL] && !last_layer)
                layer_idx_d = layer_idx_q + 1'b1;
        end
        // Registered from the next state so the enable tracks the stage exactly.
        timer_en_d = stage_en(state_d);
    end

    always_comb begin
        start_ready = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        err         = (state_q == S_ERR);
        res_valid   = (state_q == S_RESP);
        stage       = state_q;
        timer_en    = timer_en_q;
        res_cycles  = res_cycles_q;
        layer_idx   = layer_idx_q;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Frame-level controller that drives the four-channel layer delay timer bank. It accepts one frame-start handshake, then steps the CNN layer pipeline CONV → POOL (repeated N_LAYERS times) → ACT → FC. For each stage it holds the matching timer enable until that timer's done level rises, then reports total latency on a result handshake. A per-stage watchdog traps hung stages in an error state.

## Interface
- N_LAYERS, 2: CONV/POOL pair repetitions per frame, ≥1
- TIMEOUT, 4096: max cycles per stage before error, ≥2
- CYC_W, 16: width of latency counter
- S_AXIS_ACLK  in  1  sole clock, rising edge
- S_AXIS_ARESETN  in  1  reset; one clock, reset asynchronous and active-low
- start_valid  in  1  frame start request
- start_ready  out  1  high only in IDLE
- abort  in  1  synchronous clear to IDLE, any state
- timer_en  out  4  level enables to timer channels [0]=CONV [1]=POOL [2]=ACT [3]=FC
- timer_done  in  4  timer threshold-reached levels, same bit order
- res_valid  out  1  frame complete
- res_ready  in  1  result accepted
- res_cycles  out  CYC_W  frame latency, valid while res_valid
- busy  out  1  state not IDLE
- err  out  1  watchdog tripped, high in ERR
- stage  out  3  current state encoding
- layer_idx  out  $clog2(N_LAYERS+1)  current CONV/POOL iteration

## Operation
- States/encodings: IDLE=0, CONV=1, POOL=2, ACT=3, FC=4, RESP=5, ERR=6.
- IDLE: start_valid & start_ready → CONV; layer_idx←0, res_cycles←0.
- CONV: timer_done[0] → POOL.
- POOL: timer_done[1] → CONV with layer_idx+1 if layer_idx<N_LAYERS-1, else ACT.
- ACT: timer_done[2] → FC. FC: timer_done[3] → RESP.
- RESP: res_valid=1; res_ready → IDLE.
- ERR: err=1; exits only via abort or reset.
- timer_en = one-hot of CONV/POOL/ACT/FC state, registered; zero in IDLE, RESP, ERR. Exactly one bit is high at most.
- In a run state, only the matching timer_done bit is evaluated; other bits are ignored.
- Watchdog: stage counter clears on every stage entry and increments each cycle in run states. Reaching TIMEOUT-1 without done → ERR.
- Done and timeout in the same cycle: done wins.
- res_cycles increments every cycle in CONV/POOL/ACT/FC and saturates at all-ones; held in RESP/IDLE until next accept.
- abort has priority over every transition; all outputs return to reset values next cycle.
- Reset values: start_ready=1, timer_en=0, res_valid=0, res_cycles=0, busy=0, err=0, stage=0, layer_idx=0.

## Timing
- Start accepted at edge E → CONV and timer_en[0] high from E.
- Timer counters start at 0 on stage entry because the channel enable was low beforehand. Thresholds are ≥1, so done is never high on the first cycle.
- Stage length = threshold+1 cycles. The state leaves on the edge that samples done=1, and timer_en drops on that same edge.
- Default thresholds give: CONV 71, POOL 32, ACT 2, FC 1086 cycles. With N_LAYERS=2, res_cycles = 1294, and res_valid rises 1294 cycles after E.
- Back-to-back frames: IDLE lasts a minimum of one cycle after the RESP handshake; start is never accepted in RESP.
- No combinational path from inputs to outputs.

## Structure
- Package cnn_seq_pkg: state enum/encodings, channel index constants (CH_CONV=0, CH_POOL=1, CH_ACT=2, CH_FC=3), default thresholds 70/31/1/1085 for benches.
- One sub-module, seq_watchdog: clearable stage counter of width $clog2(TIMEOUT) with a timeout flag output.
- FSM, latency counter and layer counter stay in the top.

## Test plan
- Reset then an idle hold with start_valid=0 → all outputs at reset values; timer_en=0.
- Single frame with the timer model at 70/31/1/1085, N_LAYERS=2 → stage sequence 1,2,1,2,3,4,5; res_cycles=1294; timer_en stays one-hot throughout.
- RESP with res_ready held low 10 cycles → res_valid and res_cycles stable; start_valid ignored; IDLE after res_ready.
- FC timer_done tied low, TIMEOUT=4096 → ERR 4096 cycles after FC entry; err=1, timer_en=0; abort → IDLE next cycle.
- Abort asserted mid-POOL of layer 1 → IDLE next cycle, layer_idx=0, timer_en=0; a new frame then completes with res_cycles=1294.
- timer_done[3] forced high during CONV → ignored; CONV still lasts 71 cycles.
